// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter that shares one router PE injection port among N local
// requesters, holding the winning flit in a one-entry output register.
module noc_inject_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned X           = 8,
  parameter int unsigned Y           = 8,
  parameter int unsigned data_width  = 32,
  parameter int unsigned x_size      = 3,
  parameter int unsigned y_size      = 3,
  parameter int unsigned total_width = x_size + y_size + data_width,
  parameter int unsigned sel_w       = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  input  logic [N*total_width-1:0] req_data,
  output logic [N-1:0]             req_ready,
  output logic                     o_valid,
  output logic [total_width-1:0]   o_data,
  input  logic                     i_ready,
  output logic [sel_w-1:0]         o_src,
  output logic [15:0]              o_busy_cnt
);

  localparam logic [15:0] BUSY_MAX = 16'hFFFF;

  // Mesh dimensions must fit the coordinate fields carried in each flit.
  if (N < 2 || X > (1 << x_size) || Y > (1 << y_size)) begin : g_bad_params
    $error("noc_inject_arbiter: illegal parameter combination");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [sel_w-1:0] ptr_q;
  logic [sel_w-1:0] grant_idx;
  logic             any_valid;
  logic             can_load;
  logic             load;
  logic [sel_w:0]   cand;

  assign o_valid  = (state_q == FULL);
  assign can_load = ~o_valid | i_ready;
  assign load     = any_valid & can_load & ~rst;

  // Round-robin search starting at ptr, wrapping modulo N.
  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (sel_w+1)'(i);
      if (cand >= (sel_w+1)'(N)) begin
        cand = cand - (sel_w+1)'(N);
      end
      if (!any_valid && req_valid[cand[sel_w-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = cand[sel_w-1:0];
      end
    end
  end

  // Output-register occupancy and the accept strobe to the winner.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    if (load) begin
      req_ready[grant_idx] = 1'b1;
    end
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (!load && i_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State, held flit, pointer and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      o_data     <= '0;
      o_src      <= '0;
      ptr_q      <= '0;
      o_busy_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        o_data <= req_data[grant_idx*total_width +: total_width];
        o_src  <= grant_idx;
        ptr_q  <= (grant_idx == sel_w'(N-1)) ? '0 : grant_idx + sel_w'(1);
      end
      if (o_valid && !i_ready && (o_busy_cnt != BUSY_MAX)) begin
        o_busy_cnt <= o_busy_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares the single local-PE injection port of one mesh router among N local requesters, e.g. a core, a DMA engine and a debug unit on the same tile.
- Arbitrates round-robin.
- Holds the winning packet in a one-entry output register.
- Drives the router's PE-side valid/data inputs and obeys the router's PE-side ready under a valid/ready handshake.
- Packets are opaque flits of total_width bits: {dest_y, dest_x, payload}, with payload in the LSBs.

Parameters:
- N, 4, number of local requesters (N >= 2).
- X, 8, mesh columns (documentation only; not used in logic).
- Y, 8, mesh rows (documentation only; not used in logic).
- data_width, 32, payload bits.
- x_size, 3, x coordinate field bits.
- y_size, 3, y coordinate field bits.
- total_width, x_size+y_size+data_width, flit width.
- sel_w, $clog2(N), requester index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N  per-requester flit valid.
- req_data  in  N*total_width  requester k flit at [k*total_width +: total_width].
- req_ready  out  N  one-hot-or-zero accept strobe.
- o_valid  out  1  to router PE valid input.
- o_data  out  total_width  to router PE data input.
- i_ready  in  1  from router PE ready output.
- o_src  out  sel_w  index of the requester whose flit is in o_data.
- o_busy_cnt  out  16  count of cycles with o_valid=1 and i_ready=0; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clock edge):
  - o_valid=0, o_data=0, o_src=0, round-robin pointer ptr=0, o_busy_cnt=0.
  - req_ready=0 while rst=1.
  - Any held flit is discarded; a requester is not credited with a transfer during reset.
- Output register states:
  - EMPTY: o_valid=0.
  - FULL: o_valid=1.
  - EMPTY->FULL: a requester is accepted.
  - FULL->EMPTY: i_ready=1 and no new accept.
  - FULL->FULL: a drain and a new accept occur in the same cycle, or the register stalls (i_ready=0).
- Slot free: can_load = !o_valid | i_ready (combinational).
- Arbitration (combinational):
  - Winner g = first k with req_valid[k]=1, searching ptr, ptr+1, ..., wrapping modulo N.
  - req_ready[g] = can_load & !rst. All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and i_ready. Requesters must not make req_valid depend on req_ready.
- Transfer (req_valid[g] & req_ready[g]) at the clock edge:
  - o_data <= flit of g, o_src <= g, o_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1.
- No requester valid and i_ready=1: o_valid <= 0; o_data and o_src hold their last values.
- Stall (o_valid=1, i_ready=0):
  - o_data and o_src are held stable.
  - No req_ready is asserted.
  - ptr is unchanged.
  - o_busy_cnt increments, saturating at 16'hFFFF.
- Latency and throughput:
  - Accept to o_valid: 1 cycle.
  - Sustained throughput with i_ready=1 is 1 flit per cycle.
- Fairness: a continuously valid requester is granted within N transfers.
- ptr changes only on a transfer.
- A requester may drop req_valid before being granted; no state is kept for it.
- No flit is ever duplicated, dropped or reordered per requester.

Test Plan:
- Reset then idle, req_valid=0 for 10 cycles -> o_valid=0, req_ready=0, o_busy_cnt=0 throughout.
- Only requester 2 valid with flit 38'h0A_DEADBEEF, i_ready=1 -> req_ready=4'b0100 in that cycle; next cycle o_valid=1, o_data=38'h0A_DEADBEEF, o_src=2.
- All 4 requesters valid continuously, i_ready=1 -> grants 0,1,2,3,0,1,... one per cycle; each o_src matches its flit.
- FULL with i_ready=0 for 5 cycles, all requesters valid -> req_ready=0, o_data stable, o_busy_cnt=5; on i_ready=1, the next flit (ptr order) is loaded in that same cycle.
- Only requester 3 valid twice, then requesters 0 and 3 both valid -> ptr wraps to 0 after the grant to 3, so 0 is granted next.
- rst asserted while FULL and stalled with requester 1 pending -> next cycle o_valid=0, ptr=0, o_busy_cnt=0; requester 1 is granted first after rst is released.
